dmem_ctrl: RTL and testbench

Parametrised data-memory controller that replaces the bare combinational-read data array. It serves the core's load/store path over a valid/ready request channel and a registered response channel. It supports byte, halfword and word accesses with byte-lane write enables, sign or zero extension on loads, and configurable wait states. Misalignment is always flagged; out-of-range detection is optional.

---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_ctrl.sv | 109 ++++++++++
 tb/tb_dmem_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and lane helpers for the dmem_ctrl data-memory controller
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_e;

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         SZ_B:    be = 4'b0001 << addr_lo;
         SZ_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] addr_lo, input logic is_unsigned);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {addr_lo, 3'b000};
      case (size)
         SZ_B:    res = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
         SZ_H:    res = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
         SZ_W:    res = word;
         default: res = 32'd0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - MEM_WORDS x 32 synchronous-read RAM with 4-bit byte write enable
module dmem_array #(
   parameter int MEM_WORDS = 64,
   parameter int AW        = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic          i_re,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [MEM_WORDS];
   logic [31:0] r_rdata;

   // Read register only moves on a read, so held responses keep their data.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - load/store data-memory controller; optional DMEM_BOUNDS_CHECK_EN flags out-of-range addresses
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int MEM_WORDS   = 64,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         AW       = $clog2(MEM_WORDS);
   localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_e      r_state, w_next, w_start;
   logic [3:0]  r_cnt;
   logic [1:0]  r_addr_lo, r_size;
   logic        r_unsigned, r_err, r_load;
   logic        w_accept, w_misalign, w_oob, w_err;
   logic [3:0]  w_we;
   logic [31:0] w_wdata, w_q;

   assign req_ready  = (r_state == IDLE) || (r_state == RESP && rsp_ready);
   assign w_accept   = req_valid && req_ready;
   assign w_start    = (WAIT_STATES > 0) ? WAIT : RESP;
   assign w_misalign = (req_size == SZ_H && req_addr[0]) ||
                       (req_size == SZ_W && req_addr[1:0] != 2'b00);

`ifdef DMEM_BOUNDS_CHECK_EN
   assign w_oob = |req_addr[31:AW+2];
`else
   logic w_unused_addr_hi;
   assign w_unused_addr_hi = |req_addr[31:AW+2];
   assign w_oob            = 1'b0;
`endif

   assign w_err = w_misalign || (req_size == 2'b11) || w_oob;
   assign w_we  = byte_en(req_size, req_addr[1:0]) & {4{w_accept && req_we && !w_err}};

   always_comb begin
      w_wdata = req_wdata;
      case (req_size)
         SZ_B:    w_wdata = {4{req_wdata[7:0]}};
         SZ_H:    w_wdata = {2{req_wdata[15:0]}};
         default: w_wdata = req_wdata;
      endcase
   end

   dmem_array #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_array (
      .clk     (clk),
      .i_re    (w_accept && !req_we),
      .i_we    (w_we),
      .i_addr  (req_addr[AW+1:2]),
      .i_wdata (w_wdata),
      .o_rdata (w_q)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = w_start;
         WAIT:    if (r_cnt == 4'd0) w_next = RESP;
         RESP:    if (rsp_ready) w_next = w_accept ? w_start : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= 4'd0;
         r_addr_lo  <= 2'b00;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_err      <= 1'b0;
         r_load     <= 1'b0;
      end else if (w_accept) begin
         r_cnt      <= CNT_LOAD;
         r_addr_lo  <= req_addr[1:0];
         r_size     <= req_size;
         r_unsigned <= req_unsigned;
         r_err      <= w_err;
         r_load     <= !req_we && !w_err;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Response fields come only from registers: the RAM read register plus latched lane info.
   assign rsp_valid = (r_state == RESP);
   assign rsp_err   = rsp_valid && r_err;
   assign rsp_rdata = (rsp_valid && r_load) ? load_ext(w_q, r_size, r_addr_lo, r_unsigned) : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl (WAIT_STATES 0 and 3 instances)
module tb_dmem_ctrl;

   localparam int          MEM_WORDS = 64;
   localparam int unsigned MEM_BYTES = MEM_WORDS * 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, rst3;
   logic        d0_req_valid, d0_req_ready, d0_req_we, d0_req_unsigned, d0_rsp_valid, d0_rsp_ready, d0_rsp_err;
   logic [1:0]  d0_req_size;
   logic [31:0] d0_req_addr, d0_req_wdata, d0_rsp_rdata;
   logic        d3_req_valid, d3_req_ready, d3_req_we, d3_req_unsigned, d3_rsp_valid, d3_rsp_ready, d3_rsp_err;
   logic [1:0]  d3_req_size;
   logic [31:0] d3_req_addr, d3_req_wdata, d3_rsp_rdata;

   dmem_ctrl #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .reset(rst0), .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_we(d0_req_we),
      .req_size(d0_req_size), .req_unsigned(d0_req_unsigned), .req_addr(d0_req_addr),
      .req_wdata(d0_req_wdata), .rsp_valid(d0_rsp_valid), .rsp_ready(d0_rsp_ready),
      .rsp_rdata(d0_rsp_rdata), .rsp_err(d0_rsp_err)
   );

   dmem_ctrl #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(3)) u_dut3 (
      .clk(clk), .reset(rst3), .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_we(d3_req_we),
      .req_size(d3_req_size), .req_unsigned(d3_req_unsigned), .req_addr(d3_req_addr),
      .req_wdata(d3_req_wdata), .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready),
      .rsp_rdata(d3_rsp_rdata), .rsp_err(d3_rsp_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] m_mem [MEM_BYTES];

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
   endfunction

   function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
      int n;
      n = nbytes(sz);
      if (n == 0) return 1'b1;
      if ((a % 32'(n)) != 32'd0) return 1'b1;
`ifdef DMEM_BOUNDS_CHECK_EN
      if (a >= MEM_BYTES) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // Byte-addressed memory model: stores update bytes, loads assemble and extend.
   function automatic logic [31:0] m_access(input logic we, input logic [1:0] sz, input logic uns,
                                            input logic [31:0] a, input logic [31:0] wd);
      int          n;
      int unsigned base;
      logic [31:0] v;
      n = nbytes(sz);
      v = 32'd0;
      if (m_err(sz, a)) return 32'd0;
      base = a % MEM_BYTES;
      if (we) begin
         for (int i = 0; i < n; i++) m_mem[base + i] = wd[8*i +: 8];
         return 32'd0;
      end
      for (int i = 0; i < n; i++) v[8*i +: 8] = m_mem[base + i];
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   task automatic op0(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      d0_req_valid = 1'b1; d0_req_we = we; d0_req_size = sz; d0_req_unsigned = uns;
      d0_req_addr = addr; d0_req_wdata = wd; d0_rsp_ready = (hold == 0);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      d0_req_valid = 1'b0;
      while (!d0_rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rd = d0_rsp_rdata;
      er = d0_rsp_err;
      for (int h = 0; h < hold; h++) begin
         chk("hold_valid", 32'(d0_rsp_valid), 32'd1);
         chk("hold_rdata", d0_rsp_rdata, rd);
         chk("hold_err", 32'(d0_rsp_err), 32'(er));
         chk("hold_req_ready", 32'(d0_req_ready), 32'd0);
         @(negedge clk);
      end
      d0_rsp_ready = 1'b1;
      @(posedge clk);
   endtask

   task automatic op3(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      d3_req_valid = 1'b1; d3_req_we = we; d3_req_size = sz; d3_req_unsigned = uns;
      d3_req_addr = addr; d3_req_wdata = wd; d3_rsp_ready = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      d3_req_valid = 1'b0;
      chk("ws3_wait_req_ready", 32'(d3_req_ready), 32'd0);
      while (!d3_rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rd = d3_rsp_rdata;
      er = d3_rsp_err;
      @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, exp, a, wd;
      logic        er, eerr, we, uns;
      logic [1:0]  sz;
      int          lat, hold;
      vec_t        vt[18];

      vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
      vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b1, 2'd2, 1'b0, 32'h20,  32'h11223344, 32'h0,        1'b0};
      vt[3]  = '{1'b1, 2'd0, 1'b0, 32'h21,  32'hABCDEF80, 32'h0,        1'b0};
      vt[4]  = '{1'b0, 2'd0, 1'b0, 32'h21,  32'h0,        32'hFFFFFF80, 1'b0};
      vt[5]  = '{1'b0, 2'd0, 1'b1, 32'h21,  32'h0,        32'h00000080, 1'b0};
      vt[6]  = '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'h11228044, 1'b0};
      vt[7]  = '{1'b1, 2'd2, 1'b0, 32'h22,  32'hCAFEF00D, 32'h0,        1'b1};
      vt[8]  = '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'h11228044, 1'b0};
      vt[9]  = '{1'b1, 2'd1, 1'b0, 32'h32,  32'h1234BEEF, 32'h0,        1'b0};
      vt[10] = '{1'b0, 2'd1, 1'b0, 32'h32,  32'h0,        32'hFFFFBEEF, 1'b0};
      vt[11] = '{1'b0, 2'd1, 1'b1, 32'h32,  32'h0,        32'h0000BEEF, 1'b0};
      vt[12] = '{1'b0, 2'd1, 1'b0, 32'h33,  32'h0,        32'h0,        1'b1};
      vt[13] = '{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1};
      vt[14] = '{1'b1, 2'd2, 1'b0, 32'h0,   32'h0BADF00D, 32'h0,        1'b0};
`ifdef DMEM_BOUNDS_CHECK_EN
      vt[15] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1};
      vt[16] = '{1'b1, 2'd0, 1'b0, 32'h103, 32'h7F,       32'h0,        1'b1};
      vt[17] = '{1'b0, 2'd2, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 1'b0};
`else
      vt[15] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h0BADF00D, 1'b0};
      vt[16] = '{1'b1, 2'd0, 1'b0, 32'h103, 32'h7F,       32'h0,        1'b0};
      vt[17] = '{1'b0, 2'd2, 1'b0, 32'h0,   32'h0,        32'h7FADF00D, 1'b0};
`endif

      d0_req_valid = 1'b0; d0_req_we = 1'b0; d0_req_size = 2'd0; d0_req_unsigned = 1'b0;
      d0_req_addr = 32'd0; d0_req_wdata = 32'd0; d0_rsp_ready = 1'b1;
      d3_req_valid = 1'b0; d3_req_we = 1'b0; d3_req_size = 2'd0; d3_req_unsigned = 1'b0;
      d3_req_addr = 32'd0; d3_req_wdata = 32'd0; d3_rsp_ready = 1'b1;
      rst0 = 1'b0; rst3 = 1'b0;
      repeat (3) @(negedge clk);
      rst0 = 1'b1; rst3 = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(d0_req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(d0_rsp_valid), 32'd0);
      chk("rst_rsp_rdata", d0_rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(d0_rsp_err), 32'd0);
      chk("rst3_req_ready", 32'(d3_req_ready), 32'd1);
      chk("rst3_rsp_valid", 32'(d3_rsp_valid), 32'd0);

      for (int w = 0; w < MEM_WORDS; w++) begin
         wd  = $urandom;
         exp = m_access(1'b1, 2'd2, 1'b0, 32'(w * 4), wd);
         op0(1'b1, 2'd2, 1'b0, 32'(w * 4), wd, 0, rd, er, lat);
         chk("preload_err", 32'(er), 32'd0);
      end

      for (int i = 0; i < 150; i++) begin
         we   = 1'($urandom_range(0, 1));
         sz   = 2'($urandom_range(0, 3));
         uns  = 1'($urandom_range(0, 1));
         a    = 32'($urandom_range(0, 2 * MEM_BYTES - 1));
         if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
         wd   = $urandom;
         hold = int'($urandom_range(0, 2));
         eerr = m_err(sz, a);
         exp  = m_access(we, sz, uns, a, wd);
         op0(we, sz, uns, a, wd, hold, rd, er, lat);
         chk($sformatf("rnd%0d_rdata", i), rd, exp);
         chk($sformatf("rnd%0d_err", i), 32'(er), 32'(eerr));
         chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd1);
      end

      for (int i = 0; i < 18; i++) begin
         op0(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, 0, rd, er, lat);
         chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
      end

      // Back-to-back store then load of the same word, one accept per cycle.
      @(negedge clk);
      d0_req_valid = 1'b1; d0_req_we = 1'b1; d0_req_size = 2'd2; d0_req_addr = 32'h40;
      d0_req_wdata = 32'h5A5A1234; d0_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("b2b_store_valid", 32'(d0_rsp_valid), 32'd1);
      chk("b2b_store_rdata", d0_rsp_rdata, 32'd0);
      chk("b2b_req_ready", 32'(d0_req_ready), 32'd1);
      d0_req_we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      d0_req_valid = 1'b0;
      chk("raw_valid", 32'(d0_rsp_valid), 32'd1);
      chk("raw_rdata", d0_rsp_rdata, 32'h5A5A1234);
      @(posedge clk);

      // Backpressure with a pending request accepted on release.
      @(negedge clk);
      d0_req_valid = 1'b1; d0_req_we = 1'b0; d0_req_size = 2'd2; d0_req_addr = 32'h10; d0_rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      d0_req_addr = 32'h20;
      for (int c = 0; c < 3; c++) begin
         chk("bp_valid", 32'(d0_rsp_valid), 32'd1);
         chk("bp_rdata", d0_rsp_rdata, 32'hDEADBEEF);
         chk("bp_err", 32'(d0_rsp_err), 32'd0);
         chk("bp_req_ready", 32'(d0_req_ready), 32'd0);
         @(negedge clk);
      end
      d0_rsp_ready = 1'b1;
      #1;
      chk("bp_release_req_ready", 32'(d0_req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      d0_req_valid = 1'b0;
      chk("bp_next_valid", 32'(d0_rsp_valid), 32'd1);
      chk("bp_next_rdata", d0_rsp_rdata, 32'h11228044);
      @(posedge clk);
      @(negedge clk);
      chk("bp_idle_valid", 32'(d0_rsp_valid), 32'd0);

      // Wait-state instance: latency, reset during WAIT and during a held response.
      op3(1'b1, 2'd2, 1'b0, 32'h8, 32'h600DCAFE, rd, er, lat);
      chk("ws3_store_latency", 32'(lat), 32'd4);
      chk("ws3_store_err", 32'(er), 32'd0);
      op3(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, er, lat);
      chk("ws3_load_latency", 32'(lat), 32'd4);
      chk("ws3_load_rdata", rd, 32'h600DCAFE);

      @(negedge clk);
      d3_req_valid = 1'b1; d3_req_we = 1'b1; d3_req_size = 2'd2; d3_req_addr = 32'h8; d3_req_wdata = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      d3_req_valid = 1'b0;
      chk("ws3_in_wait_valid", 32'(d3_rsp_valid), 32'd0);
      chk("ws3_in_wait_ready", 32'(d3_req_ready), 32'd0);
      rst3 = 1'b0;
      #1;
      chk("ws3_rst_valid", 32'(d3_rsp_valid), 32'd0);
      chk("ws3_rst_ready", 32'(d3_req_ready), 32'd1);
      @(negedge clk);
      rst3 = 1'b1;
      @(negedge clk);
      chk("ws3_post_rst_ready", 32'(d3_req_ready), 32'd1);
      chk("ws3_post_rst_valid", 32'(d3_rsp_valid), 32'd0);
      op3(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, er, lat);
      chk("ws3_store_kept", rd, 32'h12345678);

      @(negedge clk);
      d3_req_valid = 1'b1; d3_req_we = 1'b0; d3_req_size = 2'd0; d3_req_addr = 32'hB; d3_req_unsigned = 1'b0;
      d3_rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      d3_req_valid = 1'b0;
      lat = 1;
      while (!d3_rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("ws3_held_rdata", d3_rsp_rdata, 32'h00000012);
      rst3 = 1'b0;
      #1;
      chk("ws3_rst_resp_valid", 32'(d3_rsp_valid), 32'd0);
      chk("ws3_rst_resp_rdata", d3_rsp_rdata, 32'd0);
      chk("ws3_rst_resp_err", 32'(d3_rsp_err), 32'd0);
      @(negedge clk);
      rst3 = 1'b1;
      d3_rsp_ready = 1'b1;
      @(negedge clk);
      chk("ws3_rst_resp_ready", 32'(d3_req_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
